// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: default widths, requester IDs and FSM encoding.
package dmem_arbiter_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned ADDR_SIZE = 32;
    localparam int unsigned AMP_W     = 4;

    // Requester identifiers, also used as bit positions in the grant vector
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_EXT = 1'b1;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: a tie goes to the requester that was not granted last.
module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req[REQ_CPU] && (!req[REQ_EXT] || (last == REQ_EXT))) begin
            gnt[REQ_CPU] = 1'b1;
        end else if (req[REQ_EXT]) begin
            gnt[REQ_EXT] = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the pipeline MEM stage and an external port.
// One access per three cycles: IDLE (arbitrate) -> ACCESS (drive dmem) -> RESP (ready pulse).
module dmem_arbiter #(
    parameter int unsigned XLEN      = dmem_arbiter_pkg::XLEN,
    parameter int unsigned ADDR_SIZE = dmem_arbiter_pkg::ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [ADDR_SIZE-1:0] cpu_addr,
    input  logic [XLEN-1:0]      cpu_wdata,
    input  logic [3:0]           cpu_amp,
    output logic                 cpu_ready,
    output logic                 cpu_stall,

    input  logic                 ext_req,
    input  logic                 ext_we,
    input  logic [ADDR_SIZE-1:0] ext_addr,
    input  logic [XLEN-1:0]      ext_wdata,
    input  logic [3:0]           ext_amp,
    output logic                 ext_ready,

    output logic [XLEN-1:0]      rdata,

    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [XLEN-1:0]      mem_wdata,
    output logic [3:0]           mem_amp,
    input  logic [XLEN-1:0]      mem_rdata
);

    import dmem_arbiter_pkg::*;

    arb_state_e           state_q, state_d;
    logic                 owner_q;
    logic                 last_q;
    logic                 cmd_we_q;
    logic [ADDR_SIZE-1:0] cmd_addr_q;
    logic [XLEN-1:0]      cmd_wdata_q;
    logic [3:0]           cmd_amp_q;
    logic [XLEN-1:0]      rdata_q;

    logic [1:0]           gnt;
    logic                 accept;
    logic                 win_ext;

    rr_arb2 u_rr_arb2 (
        .req  ({ext_req, cpu_req}),
        .last (last_q),
        .gnt  (gnt)
    );

    assign win_ext = gnt[REQ_EXT];

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cpu_req || ext_req) begin
                    state_d = StAccess;
                    accept  = 1'b1;
                end
            end
            StAccess: state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            owner_q     <= REQ_CPU;
            last_q      <= REQ_EXT;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cmd_amp_q   <= '0;
            rdata_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q     <= win_ext ? REQ_EXT : REQ_CPU;
                last_q      <= win_ext ? REQ_EXT : REQ_CPU;
                cmd_we_q    <= win_ext ? ext_we : cpu_we;
                cmd_addr_q  <= win_ext ? ext_addr : cpu_addr;
                cmd_wdata_q <= win_ext ? ext_wdata : cpu_wdata;
                cmd_amp_q   <= win_ext ? ext_amp : cpu_amp;
            end
            if ((state_q == StAccess) && !cmd_we_q) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    // mem_we is decoded from the state register so an asynchronous reset kills it at once
    assign mem_we    = (state_q == StAccess) && cmd_we_q;
    assign mem_addr  = cmd_addr_q;
    assign mem_wdata = cmd_wdata_q;
    assign mem_amp   = cmd_amp_q;

    assign cpu_ready = (state_q == StResp) && (owner_q == REQ_CPU);
    assign ext_ready = (state_q == StResp) && (owner_q == REQ_EXT);
    assign cpu_stall = cpu_req && !cpu_ready;
    assign rdata     = rdata_q;

endmodule
